// File: rtl/spilling_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spilling_pkg
// Description : State codes, parameter defaults and display codes for the
//               Spilling transmit arbiter.
// Revision    : 1.0
// ============================================================================
package spilling_pkg;

    localparam int c_NREQ_DEF   = 3;
    localparam int c_NBYTES_DEF = 4;
    localparam int c_TO_W_DEF   = 16;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SEND  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_NEXT  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;
    localparam logic [2:0] c_ST_ABORT = 3'd6;

    localparam logic [3:0] c_DB_ERR = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/spilling_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : spilling_rr_pick
// Description : Combinational round-robin picker; scans last+1, last+2, ...
// Revision    : 1.0
// ============================================================================
module spilling_rr_pick #(
    parameter int NREQ = 3,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last,
    output logic            valid,
    output logic [GW-1:0]   winner
);

    logic [GW-1:0] w_pos;

    // Scan from farthest to nearest so the nearest set request is assigned last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_pos  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = GW'((int'(last) + k) % NREQ);
            if (req[w_pos]) begin
                valid  = 1'b1;
                winner = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spilling_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : spilling_tx_arb
// Description : Round-robin arbiter sequencing fixed-length frames into the
//               shared serial transmitter, with a stall watchdog.
// Revision    : 1.0
// ============================================================================
module spilling_tx_arb
    import spilling_pkg::*;
#(
    parameter int NREQ   = c_NREQ_DEF,
    parameter int NBYTES = c_NBYTES_DEF,
    parameter int TO_W   = c_TO_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*NBYTES*8-1:0] frame,
    input  logic                     pronto_serial,
    output logic                     partida_tx,
    output logic [7:0]               tx_dado,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          abort,
    output logic                     busy,
    output logic [3:0]               db_estado
);

    localparam int c_GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int c_FW = NBYTES * 8;

    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NBYTES - 1);
    localparam logic [TO_W-1:0] c_CNT_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_GW-1:0] r_last;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] w_idx_inc;
    logic [TO_W-1:0] r_cnt;
    logic [c_FW-1:0] r_frame;
    logic [c_FW-1:0] w_frame_sel;
    logic [7:0]      r_tx_dado;
    logic            w_valid;
    logic [c_GW-1:0] w_winner;
    logic [NREQ-1:0] w_grant_oh;

    spilling_rr_pick #(
        .NREQ (NREQ),
        .GW   (c_GW)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .valid  (w_valid),
        .winner (w_winner)
    );

    // The winner is captured into r_last on leaving IDLE, so LOAD no longer
    // depends on req and uses r_last as the grant.
    assign w_frame_sel = frame[r_last*c_FW +: c_FW];
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_grant_oh  = NREQ'(1) << r_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_valid) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:  w_state_nxt = c_ST_SEND;
            c_ST_SEND:  w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                if (pronto_serial) begin
                    w_state_nxt = (r_idx == c_IDX_LAST) ? c_ST_DONE : c_ST_NEXT;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_ABORT;
                end
            end
            c_ST_NEXT:  w_state_nxt = c_ST_SEND;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            c_ST_ABORT: w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        partida_tx = (r_state == c_ST_SEND);
        busy       = (r_state != c_ST_IDLE);
        ack        = (r_state == c_ST_DONE)  ? w_grant_oh : '0;
        abort      = (r_state == c_ST_ABORT) ? w_grant_oh : '0;
        tx_dado    = r_tx_dado;
        db_estado  = (r_state <= c_ST_ABORT) ? {1'b0, r_state} : c_DB_ERR;
    end

    // tx_dado is loaded one cycle ahead of SEND so it is valid with partida_tx.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last    <= c_GW'(NREQ - 1);
            r_idx     <= '0;
            r_cnt     <= '0;
            r_frame   <= '0;
            r_tx_dado <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx_dado <= '0;
                    if (w_valid) r_last <= w_winner;
                end
                c_ST_LOAD: begin
                    r_frame   <= w_frame_sel;
                    r_idx     <= '0;
                    r_tx_dado <= w_frame_sel[7:0];
                end
                c_ST_SEND: r_cnt <= '0;
                c_ST_WAIT: r_cnt <= r_cnt + 1'b1;
                c_ST_NEXT: begin
                    r_idx     <= w_idx_inc;
                    r_tx_dado <= r_frame[w_idx_inc*8 +: 8];
                end
                default:   r_tx_dado <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire
